// File: rtl/ept_uc_out_arbiter.sv
// ept_uc_out_arbiter: round-robin owner of the shared 22-bit uc_out channel with ack/timeout and idle gap
module ept_uc_out_arbiter #(
    parameter int N              = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GAP_CYCLES     = 2
) (
    input  logic            CLK_66,
    input  logic            RST,
    input  logic [N-1:0]    req,
    input  logic [N*22-1:0] uc_out_m,
    output logic [N-1:0]    gnt,
    output logic [21:0]     uc_out,
    output logic            uc_out_valid,
    input  logic            uc_ack,
    output logic [N-1:0]    done,
    output logic            timeout_err
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t          r_state, w_state;
    logic [N-1:0]    r_gnt, w_gnt, r_done, w_done;
    logic [21:0]     r_out, w_out;
    logic            r_valid, w_valid, r_terr, w_terr;
    logic [PW-1:0]   r_ptr, w_ptr, r_idx, w_idx, w_win, w_ptr_next;
    logic [TW-1:0]   r_timer, w_timer;
    logic [GW-1:0]   r_gap, w_gap;
    logic            w_found, w_tmo;
    logic [21:0]     w_words [N];

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int i);
        int j;
        j = int'(p) + i;
        if (j >= N) j -= N;
        return PW'(j);
    endfunction

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_words
            assign w_words[g] = uc_out_m[g*22 +: 22];
        end
    endgenerate

    assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_ptr_next = (r_idx == PW'(N - 1)) ? '0 : r_idx + PW'(1);

    // search from the pointer upward, wrapping; the closest requester wins
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[rr_idx(r_ptr, i)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, i);
            end
        end
    end

    // next state and registered outputs; ack takes priority over a coincident timeout
    always_comb begin
        w_state = r_state;
        w_gnt   = r_gnt;
        w_out   = r_out;
        w_valid = r_valid;
        w_done  = '0;
        w_terr  = r_terr;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_timer = r_timer;
        w_gap   = r_gap;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state = S_BUSY;
                    w_gnt   = N'(1) << w_win;
                    w_out   = w_words[w_win];
                    w_valid = 1'b1;
                    w_timer = '0;
                    w_idx   = w_win;
                end
            end
            S_BUSY: begin
                w_timer = (r_timer == '1) ? r_timer : r_timer + TW'(1);
                if (uc_ack || w_tmo) begin
                    w_state = S_GAP;
                    w_gnt   = '0;
                    w_out   = '0;
                    w_valid = 1'b0;
                    w_done  = uc_ack ? r_gnt : '0;
                    w_terr  = r_terr | ~uc_ack;
                    w_ptr   = w_ptr_next;
                    w_gap   = '0;
                end
            end
            S_GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) w_state = S_IDLE;
                else w_gap = r_gap + GW'(1);
            end
            default: w_state = S_IDLE;
        endcase
    end

    // state register; reset drops any in-flight transfer without a done pulse
    always_ff @(posedge CLK_66) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_done  <= '0;
            r_terr  <= 1'b0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_out   <= w_out;
            r_valid <= w_valid;
            r_done  <= w_done;
            r_terr  <= w_terr;
            r_ptr   <= w_ptr;
            r_idx   <= w_idx;
            r_timer <= w_timer;
            r_gap   <= w_gap;
        end
    end

    assign gnt          = r_gnt;
    assign uc_out       = r_out;
    assign uc_out_valid = r_valid;
    assign done         = r_done;
    assign timeout_err  = r_terr;
endmodule

// File: tb/tb_ept_uc_out_arbiter.sv
// tb_ept_uc_out_arbiter: directed tests for reset, single transfer, round robin, timeout, freeze and mid-transfer reset
module tb_ept_uc_out_arbiter;
    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int GAP = 2;

    logic          CLK_66 = 1'b0;
    logic          RST    = 1'b1;
    logic [N-1:0]  req    = '0;
    logic [N*22-1:0] uc_out_m = '0;
    logic [N-1:0]  gnt, done;
    logic [21:0]   uc_out;
    logic          uc_out_valid, uc_ack = 1'b0, timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [21:0] words [N] = '{22'h0F0F1, 22'h15A5A, 22'h2A5A5, 22'h3C3C3};

    ept_uc_out_arbiter #(.N(N), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .CLK_66(CLK_66), .RST(RST), .req(req), .uc_out_m(uc_out_m), .gnt(gnt),
        .uc_out(uc_out), .uc_out_valid(uc_out_valid), .uc_ack(uc_ack),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 CLK_66 = ~CLK_66;

    task automatic tick();
        @(posedge CLK_66);
        #1;
    endtask

    task automatic load_words();
        for (int i = 0; i < N; i++) uc_out_m[i*22 +: 22] = words[i];
    endtask

    task automatic do_reset();
        RST = 1'b1; req = '0; uc_ack = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; req = '1; uc_ack = 1'b0; load_words();
        repeat (3) tick();
        n_tests++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_tests++; if (uc_out !== 22'h0) begin n_fail++; $display("FAIL reset_uc_out got %h want 0", uc_out); end
        n_tests++; if (uc_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", uc_out_valid); end
        n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done got %b want 0000", done); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got %b want 0", timeout_err); end
        req = '0; RST = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req = 4'b0100;
        tick();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got %b want 0100", gnt); end
        n_tests++; if (uc_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", uc_out_valid); end
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (uc_out !== 22'h2A5A5) begin n_fail++; $display("FAIL single_word c%0d got %h want 2a5a5", c, uc_out); end
            if (c < 2) tick();
        end
        uc_ack = 1'b1; req = '0;
        tick();
        uc_ack = 1'b0;
        n_tests++; if (done !== 4'b0100) begin n_fail++; $display("FAIL single_done got %b want 0100", done); end
        n_tests++; if (uc_out_valid !== 1'b0 || gnt !== 4'b0 || uc_out !== 22'h0) begin
            n_fail++; $display("FAIL single_release got v=%b g=%b o=%h want 0/0000/0", uc_out_valid, gnt, uc_out); end
        uc_ack = 1'b1;
        tick();
        uc_ack = 1'b0;
        n_tests++; if (done !== 4'b0 || uc_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_gap got done=%b v=%b want 0000/0", done, uc_out_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int idle;
            idle = 0;
            while (uc_out_valid !== 1'b1 && idle < 20) begin tick(); idle++; end
            n_tests++; if (gnt !== 4'(1 << (g % 4))) begin n_fail++; $display("FAIL rr_gnt%0d got %b want %b", g, gnt, 4'(1 << (g % 4))); end
            n_tests++; if (uc_out !== words[g % 4]) begin n_fail++; $display("FAIL rr_word%0d got %h want %h", g, uc_out, words[g % 4]); end
            if (g > 0) begin
                n_tests++; if (idle != GAP + 1) begin n_fail++; $display("FAIL rr_spacing%0d got %0d want %0d", g, idle, GAP + 1); end
            end
            tick();
            uc_ack = 1'b1;
            tick();
            uc_ack = 1'b0;
            n_tests++; if (done !== 4'(1 << (g % 4))) begin n_fail++; $display("FAIL rr_done%0d got %b want %b", g, done, 4'(1 << (g % 4))); end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0001;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_gnt got %b want 0001", gnt); end
        for (int c = 1; c < TMO; c++) begin
            tick();
            n_tests++; if (uc_out_valid !== 1'b1 || done !== 4'b0) begin
                n_fail++; $display("FAIL tmo_hold%0d got v=%b done=%b want 1/0000", c, uc_out_valid, done); end
        end
        req = 4'b0011;
        tick();
        n_tests++; if (uc_out_valid !== 1'b0 || gnt !== 4'b0) begin
            n_fail++; $display("FAIL tmo_drop got v=%b g=%b want 0/0000", uc_out_valid, gnt); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", timeout_err); end
        n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL tmo_done got %b want 0000", done); end
        repeat (3) tick();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL tmo_next got %b want 0010", gnt); end
        uc_ack = 1'b1; req = '0;
        tick();
        uc_ack = 1'b0;
        n_tests++; if (done !== 4'b0010) begin n_fail++; $display("FAIL tmo_next_done got %b want 0010", done); end
        n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
        repeat (3) tick();
    endtask

    task automatic test_freeze_edge();
        do_reset();
        load_words();
        req = 4'b0001;
        tick();
        uc_out_m[21:0] = 22'h3FFFF; req = '0;
        tick();
        tick();
        n_tests++; if (uc_out !== 22'h0F0F1 || gnt !== 4'b0001) begin
            n_fail++; $display("FAIL freeze got o=%h g=%b want 0f0f1/0001", uc_out, gnt); end
        repeat (5) tick();
        uc_ack = 1'b1;
        tick();
        uc_ack = 1'b0;
        n_tests++; if (done !== 4'b0001) begin n_fail++; $display("FAIL edge_done got %b want 0001", done); end
        n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL edge_terr got %b want 0", timeout_err); end
        load_words();
        repeat (3) tick();
    endtask

    task automatic test_reset_mid_busy();
        req = 4'b0100;
        tick();
        n_tests++; if (gnt !== 4'b0100 || uc_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre got g=%b v=%b want 0100/1", gnt, uc_out_valid); end
        RST = 1'b1; uc_ack = 1'b1;
        tick();
        RST = 1'b0; uc_ack = 1'b0;
        n_tests++; if (gnt !== 4'b0 || uc_out !== 22'h0 || uc_out_valid !== 1'b0 || done !== 4'b0) begin
            n_fail++; $display("FAIL rmid_zero got g=%b o=%h v=%b d=%b want all 0", gnt, uc_out, uc_out_valid, done); end
        req = 4'b1111;
        tick();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rmid_ptr got %b want 0001", gnt); end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_freeze_edge();
        test_reset_mid_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
